// File: rtl/qoi_decoder.sv
`default_nettype none
// ============================================================================
// Module   : qoi_decoder
// Purpose  : Streaming QOI chunk decoder. Accepts one encoded byte per
//            in_valid/in_ready transfer and produces 32-bit RGBA pixels on a
//            px_valid/px_ready handshake until SIZE pixels have been taken.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start, size     - frame start pulse and pixel count (IDLE only)
//            in_data/valid/ready - encoded byte stream
//            px_o/valid/ready    - pixel stream, r[7:0] g[15:8] b[23:16] a[31:24]
//            busy, done, count   - status: not IDLE, end-of-frame pulse,
//                                  pixels accepted in this frame
//            err             - only with QOI_DEC_ERR_EN: sticky flag for a RUN
//                              longer than the pixels left, or an INDEX hit on
//                              an entry not written since start
// Options  : `define QOI_DEC_ERR_EN adds the err port and its tracking logic.
// Revision : 1.0 - initial release
// ============================================================================
module qoi_decoder #(
  parameter int SIZE_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       px_o,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              busy,
  output logic              done,
  output logic [SIZE_W-1:0] count
`ifdef QOI_DEC_ERR_EN
  ,
  output logic              err
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TAG  = 3'd1;
  localparam logic [2:0] S_ARG  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;

  localparam logic [31:0] PREV_INIT = 32'hFF00_0000;

  logic [2:0]        state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] count_q, count_d;
  logic [31:0]       prev_q, prev_d;
  logic [31:0]       pix_q, pix_d;
  logic [7:0]        tag_q, tag_d;
  logic [1:0]        arg_q, arg_d;
  logic [5:0]        run_q, run_d;
  logic              done_q, done_d;
  logic [31:0]       index_q [64];

  logic              w_clear;
  logic              w_idx_we;
  logic              w_tag_long;
  logic              w_arg_last;
  logic [5:0]        w_hash;
  logic [7:0]        w_dg;
  logic [31:0]       w_diff_px;
  logic [31:0]       w_luma_px;
  logic [SIZE_W-1:0] w_count_inc;

  // 0xFE / 0xFF share the RUN tag prefix, so they must be detected first.
  assign w_tag_long  = (in_data[7:1] == 7'h7F);
  // Last argument: byte 2 for RGB (tag bit0 = 0), byte 3 for RGBA.
  assign w_arg_last  = (arg_q == 2'd3) || ((arg_q == 2'd2) && !tag_q[0]);
  assign w_clear     = (state_q == S_IDLE) && start && (size != '0);
  assign w_count_inc = count_q + SIZE_W'(1);

  // Only the low 6 bits of each channel can affect a mod-64 sum.
  assign w_hash = pix_q[5:0] * 6'd3 + pix_q[13:8] * 6'd5
                + pix_q[21:16] * 6'd7 + pix_q[29:24] * 6'd11;

  assign w_diff_px = {prev_q[31:24],
                      prev_q[23:16] + {6'd0, in_data[1:0]} - 8'd2,
                      prev_q[15:8]  + {6'd0, in_data[3:2]} - 8'd2,
                      prev_q[7:0]   + {6'd0, in_data[5:4]} - 8'd2};

  // LUMA: green delta lives in the held tag, red/blue offsets in the arg byte.
  assign w_dg      = {2'b00, tag_q[5:0]} - 8'd32;
  assign w_luma_px = {prev_q[31:24],
                      prev_q[23:16] + w_dg + {4'd0, in_data[3:0]} - 8'd8,
                      prev_q[15:8]  + w_dg,
                      prev_q[7:0]   + w_dg + {4'd0, in_data[7:4]} - 8'd8};

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    count_d  = count_q;
    prev_d   = prev_q;
    pix_d    = pix_q;
    tag_d    = tag_q;
    arg_d    = arg_q;
    run_d    = run_q;
    done_d   = 1'b0;
    w_idx_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (size == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_TAG;
            size_d  = size;
            count_d = '0;
            prev_d  = PREV_INIT;
          end
        end
      end
      S_TAG: begin
        if (in_valid) begin
          tag_d = in_data;
          arg_d = 2'd0;
          // RGB keeps prev alpha; RUN repeats prev; ARG bytes overwrite lanes.
          pix_d = prev_q;
          if (w_tag_long) begin
            state_d = S_ARG;
          end else begin
            case (in_data[7:6])
              2'b00: begin
                pix_d   = index_q[in_data[5:0]];
                state_d = S_EMIT;
              end
              2'b01: begin
                pix_d   = w_diff_px;
                state_d = S_EMIT;
              end
              2'b10: state_d = S_ARG;
              default: begin
                run_d   = in_data[5:0] + 6'd1;
                state_d = S_RUN;
              end
            endcase
          end
        end
      end
      S_ARG: begin
        if (in_valid) begin
          if (tag_q[7:6] == 2'b10) begin
            pix_d   = w_luma_px;
            state_d = S_EMIT;
          end else begin
            case (arg_q)
              2'd0:    pix_d[7:0]   = in_data;
              2'd1:    pix_d[15:8]  = in_data;
              2'd2:    pix_d[23:16] = in_data;
              default: pix_d[31:24] = in_data;
            endcase
            if (w_arg_last) state_d = S_EMIT;
            else            arg_d   = arg_q + 2'd1;
          end
        end
      end
      S_EMIT: begin
        if (px_ready) begin
          prev_d   = pix_q;
          w_idx_we = 1'b1;
          count_d  = w_count_inc;
          if (w_count_inc == size_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_TAG;
          end
        end
      end
      S_RUN: begin
        // pix_q already equals prev_q here, so prev needs no update.
        if (px_ready) begin
          w_idx_we = 1'b1;
          count_d  = w_count_inc;
          run_d    = run_q - 6'd1;
          if (w_count_inc == size_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            run_d   = '0;
          end else if (run_q == 6'd1) begin
            state_d = S_TAG;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      count_q <= '0;
      prev_q  <= PREV_INIT;
      pix_q   <= '0;
      tag_q   <= '0;
      arg_q   <= '0;
      run_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      count_q <= count_d;
      prev_q  <= prev_d;
      pix_q   <= pix_d;
      tag_q   <= tag_d;
      arg_q   <= arg_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int i = 0; i < 64; i++) index_q[i] <= '0;
    end else if (w_idx_we) begin
      index_q[w_hash] <= pix_q;
    end
  end

`ifdef QOI_DEC_ERR_EN
  logic [63:0]       written_q;
  logic              err_q;
  logic [SIZE_W-1:0] w_run_len;

  assign w_run_len = SIZE_W'(in_data[5:0]) + SIZE_W'(1);

  always_ff @(posedge clk) begin
    if (rst || ((state_q == S_IDLE) && start)) begin
      written_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (w_idx_we) written_q[w_hash] <= 1'b1;
      if ((state_q == S_TAG) && in_valid && !w_tag_long) begin
        if ((in_data[7:6] == 2'b00) && !written_q[in_data[5:0]]) err_q <= 1'b1;
        if ((in_data[7:6] == 2'b11) && (w_run_len > (size_q - count_q))) err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`endif

  assign in_ready = (state_q == S_TAG) || (state_q == S_ARG);
  assign px_valid = (state_q == S_EMIT) || (state_q == S_RUN);
  assign px_o     = pix_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: doc/qoi_decoder.md
QOI_DECODER -- requirements
Module: qoi_decoder

Interface
REQ-001 SHALL have parameter: SIZE_W, 30, width of the pixel-count fields.
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle pulse that begins decoding a frame.
REQ-005 SHALL have port: size  input  SIZE_W  total pixels in the frame, sampled on start.
REQ-006 SHALL have port: in_data  input  8  encoded QOI chunk byte.
REQ-007 SHALL have port: in_valid  input  1  in_data valid.
REQ-008 SHALL have port: in_ready  output  1  decoder accepts in_data this cycle.
REQ-009 SHALL have port: px_o  output  32  decoded pixel; r[7:0], g[15:8], b[23:16], a[31:24].
REQ-010 SHALL have port: px_valid  output  1  px_o valid.
REQ-011 SHALL have port: px_ready  input  1  sink accepts px_o.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-014 SHALL have port: count  output  SIZE_W  pixels accepted by the sink in the current frame.

Function
REQ-015 SHALL implement states IDLE, TAG, ARG, EMIT, RUN.
REQ-016 IDLE: in_ready=0, px_valid=0; start with size>0 -> TAG, clear count, prev={a=255,b=0,g=0,r=0}, clear all 64 index entries to 0; start with size=0 -> done pulse, remain IDLE.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 TAG: in_ready=1; byte transfers on in_valid&in_ready; tag decode: 0xFE RGB (3 args), 0xFF RGBA (4 args), 2'b00 INDEX, 2'b01 DIFF, 2'b10 LUMA (1 arg), 2'b11 RUN (len = low6+1, 1..62).
REQ-019 Zero-arg ops SHALL compute the pixel in the accepting cycle and go to EMIT (INDEX, DIFF) or RUN (RUN) next cycle.
REQ-020 ARG: in_ready=1; one argument byte per transfer, r,g,b[,a] order for RGB/RGBA; RGB keeps prev alpha; after final arg -> EMIT.
REQ-021 DIFF: r/g/b = prev + (field - 2) for fields [5:4],[3:2],[1:0]; alpha unchanged; all channel math modulo 256.
REQ-022 LUMA: dg = tag[5:0]-32; r = prev.r+dg+(arg[7:4]-8); g = prev.g+dg; b = prev.b+dg+(arg[3:0]-8); modulo 256.
REQ-023 INDEX: pixel = index[tag[5:0]].
REQ-024 EMIT: in_ready=0, px_valid=1, px_o stable until px_ready; on acceptance: prev<=pixel, index[(r*3+g*5+b*7+a*11) mod 64]<=pixel, count+1; if count+1==size -> done pulse, IDLE; else -> TAG.
REQ-025 RUN: px_valid=1, px_o=prev; each acceptance decrements remaining run and increments count; run exhausted -> TAG; count reaching size mid-run -> done, IDLE, remaining run discarded.
REQ-026 RUN pixels SHALL update the index (same hash write as EMIT).
REQ-027 px_valid SHALL never drop without acceptance; in_valid low SHALL stall TAG/ARG without state change.
REQ-028 No bytes SHALL be accepted after the last pixel; trailing stream bytes (end marker) are left to the caller.

Reset
REQ-029 rst SHALL force IDLE, in_ready=0, px_valid=0, busy=0, done=0, count=0, px_o=0, prev={255,0,0,0}, index cleared, run/arg counters 0.
REQ-030 rst mid-frame SHALL abandon the frame with no done pulse; first cycle after rst release accepts start.

Configuration
REQ-031 Macro QOI_DEC_ERR_EN: when defined, SHALL add port err (output, 1), sticky-set when a RUN length exceeds remaining pixels or an INDEX hits an entry never written since start; cleared by start and rst.
REQ-032 Without QOI_DEC_ERR_EN, port err SHALL be absent and such conditions decode silently per REQ-023/REQ-025.

Verification
REQ-033 size=1, bytes FE 10 20 30 -> one pixel px_o=0xFF302010, done pulse, in_ready=0 after.
REQ-034 size=3, bytes FF 01 02 03 80, 6A (DIFF +0,+0,+0 then dr=+1? tag 0x6A) -> px 0x80030201, then 0x80030201+{r+0,g+0,b+0} per fields 2,2,2... bench uses 0x6A: r+0,g+0,b+0 -> second px 0x80030201; third pixel via C0 -> repeat; done after 3.
REQ-035 size=5, bytes FE 05 05 05, C3 -> one RGB pixel then run truncated at 4 more (len 4 requested, 4 fit): 5 px of 0xFF050505, done; with QOI_DEC_ERR_EN err=0; size=4 same stream -> err=1.
REQ-036 LUMA from prev 0xFF000000: bytes A2, 88 -> dg=+2, px_o=0xFF020202; hold px_ready=0 10 cycles -> px_o stable, in_ready=0.
REQ-037 INDEX reuse: FE 0A 0B 0C, FE 01 01 01, then 00|hash(0A,0B,0C,FF) -> third px 0xFF0C0B0A; assert rst during ARG of second op -> no done, IDLE, count=0.
